host_rom_loader: RTL and testbench

//  Receives boot ROM images (OS, BASIC, AMSDOS) from the control module as 32-bit words over
//  a req/ack handshake. Unpacks each word into bytes and writes them sequentially into

---
 rtl/host_rom_loader_if.sv | 33 +++
 rtl/host_rom_loader.sv | 184 ++++++++++++++++++
 tb/tb_host_rom_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/host_rom_loader_if.sv
// Boot-data handshake from the control module plus the SRAM romwrite port.
interface host_rom_loader_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 19;

    logic [DATA_W-1:0] host_bootdata;
    logic              host_bootdata_req;
    logic              host_bootdata_ack;
    logic [BYTE_W-1:0] romwrite_data;
    logic [ADDR_W-1:0] romwrite_addr;
    logic              romwrite_wr;

    // Host / memory-manager side
    modport master (
        output host_bootdata,
        output host_bootdata_req,
        input  host_bootdata_ack,
        input  romwrite_data,
        input  romwrite_addr,
        input  romwrite_wr
    );

    // Loader side
    modport slave (
        input  host_bootdata,
        input  host_bootdata_req,
        output host_bootdata_ack,
        output romwrite_data,
        output romwrite_addr,
        output romwrite_wr
    );
endinterface

// File: rtl/host_rom_loader.sv
// Unpacks 32-bit boot words (MSB first) into byte writes to SRAM and
// holds rom_initialised low until the whole image has been written.
module host_rom_loader #(
    parameter bit          CONFIG_ON_STARTUP = 1'b1,
    parameter logic [18:0] ROM_LOCATION      = 19'h5c000,
    parameter int unsigned ROM_BYTES         = 65536,
    parameter int unsigned WR_PULSE          = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_reset,
    host_rom_loader_if.slave bus,
    output logic             rom_initialised
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned CNT_W   = 20;
    localparam int unsigned PULSE_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

    typedef enum logic [2:0] {
        S_WAIT_WORD,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PULSE_W-1:0]  pulse_q, pulse_d;
    logic                armed_q, armed_d;
    logic                ack_q, ack_d;
    logic                wr_q, wr_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                init_q, init_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic                last_byte;
    logic                pulse_last;
    logic                capture;
    logic [1:0]          idx_inc;
    logic [BYTE_W-1:0]   byte_next;

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign last_byte  = (cnt_inc == CNT_W'(ROM_BYTES));
    assign pulse_last = (pulse_q == PULSE_W'(WR_PULSE - 1));
    assign capture    = (state_q == S_WAIT_WORD) && bus.host_bootdata_req && armed_q;
    assign idx_inc    = idx_q + 2'd1;

    // Byte of the held word for the following SETUP, MSB first
    always_comb begin
        byte_next = word_q[31:24];
        unique case (idx_inc)
            2'd0: byte_next = word_q[31:24];
            2'd1: byte_next = word_q[23:16];
            2'd2: byte_next = word_q[15:8];
            2'd3: byte_next = word_q[7:0];
            default: byte_next = word_q[31:24];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CONFIG_ON_STARTUP ? S_WAIT_WORD : S_DONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; host_reset restarts the load from any state
    always_comb begin
        state_d = state_q;
        if (host_reset) begin
            state_d = S_WAIT_WORD;
        end else begin
            unique case (state_q)
                S_WAIT_WORD: if (capture) state_d = S_SETUP;
                S_SETUP:     state_d = S_STROBE;
                S_STROBE:    if (pulse_last) state_d = S_HOLD;
                S_HOLD: begin
                    if (last_byte)          state_d = S_DONE;
                    else if (idx_q != 2'd3) state_d = S_SETUP;
                    else                    state_d = S_WAIT_WORD;
                end
                S_DONE:      state_d = S_DONE;
                default:     state_d = S_WAIT_WORD;
            endcase
        end
    end

    // Output / datapath next values, registered below
    always_comb begin
        ack_d   = 1'b0;
        wr_d    = 1'b0;
        data_d  = data_q;
        addr_d  = addr_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        init_d  = init_q;
        armed_d = bus.host_bootdata_req ? armed_q : 1'b1;
        if (host_reset) begin
            addr_d  = ROM_LOCATION;
            cnt_d   = '0;
            idx_d   = '0;
            pulse_d = '0;
            init_d  = 1'b0;
            armed_d = 1'b1;
        end else begin
            unique case (state_q)
                S_WAIT_WORD: begin
                    if (capture) begin
                        word_d  = bus.host_bootdata;
                        data_d  = bus.host_bootdata[31:24];
                        idx_d   = '0;
                        ack_d   = 1'b1;
                        armed_d = 1'b0;
                    end
                end
                S_SETUP: begin
                    wr_d    = 1'b1;
                    pulse_d = '0;
                end
                S_STROBE: begin
                    wr_d    = ~pulse_last;
                    pulse_d = pulse_q + PULSE_W'(1);
                end
                S_HOLD: begin
                    cnt_d = cnt_inc;
                    if (last_byte) begin
                        init_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (idx_q != 2'd3) begin
                            idx_d  = idx_inc;
                            data_d = byte_next;
                        end
                    end
                end
                S_DONE: init_d = 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
            armed_q <= 1'b1;
            ack_q   <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= ROM_LOCATION;
            init_q  <= ~CONFIG_ON_STARTUP;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            armed_q <= armed_d;
            ack_q   <= ack_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            init_q  <= init_d;
        end
    end

    assign bus.host_bootdata_ack = ack_q;
    assign bus.romwrite_wr       = wr_q;
    assign bus.romwrite_data     = data_q;
    assign bus.romwrite_addr     = addr_q;
    assign rom_initialised       = init_q;
endmodule

// File: tb/tb_host_rom_loader.sv
// Bench for host_rom_loader: four differently parameterised instances driven
// in turn, with a byte-stream reference model checking every SRAM write.
module tb_host_rom_loader;
    localparam logic [18:0] LOC_STD  = 19'h5c000;
    localparam logic [18:0] LOC_WRAP = 19'h7fffe;

    logic        clk;
    logic        reset;
    logic [31:0] bd    [4];
    logic        req   [4];
    logic        hr    [4];
    logic        ack   [4];
    logic [7:0]  wdat  [4];
    logic [18:0] wadr  [4];
    logic        wr    [4];
    logic        rinit [4];

    int n_checks;
    int n_errors;

    // reference model state
    logic [7:0]  exp_byte [4][64];
    int          exp_n    [4];
    int          got_n    [4];
    bit          in_pulse [4];
    int          plen     [4];
    logic [7:0]  cur_d    [4];
    logic [18:0] cur_a    [4];
    logic [7:0]  prev_d   [4];
    logic [18:0] prev_a   [4];
    bit          exp_init [4];

    host_rom_loader_if bus_a ();
    host_rom_loader_if bus_b ();
    host_rom_loader_if bus_c ();
    host_rom_loader_if bus_d ();

    assign bus_a.host_bootdata = bd[0];  assign bus_a.host_bootdata_req = req[0];
    assign bus_b.host_bootdata = bd[1];  assign bus_b.host_bootdata_req = req[1];
    assign bus_c.host_bootdata = bd[2];  assign bus_c.host_bootdata_req = req[2];
    assign bus_d.host_bootdata = bd[3];  assign bus_d.host_bootdata_req = req[3];

    assign ack[0] = bus_a.host_bootdata_ack; assign wr[0] = bus_a.romwrite_wr;
    assign ack[1] = bus_b.host_bootdata_ack; assign wr[1] = bus_b.romwrite_wr;
    assign ack[2] = bus_c.host_bootdata_ack; assign wr[2] = bus_c.romwrite_wr;
    assign ack[3] = bus_d.host_bootdata_ack; assign wr[3] = bus_d.romwrite_wr;
    assign wdat[0] = bus_a.romwrite_data;    assign wadr[0] = bus_a.romwrite_addr;
    assign wdat[1] = bus_b.romwrite_data;    assign wadr[1] = bus_b.romwrite_addr;
    assign wdat[2] = bus_c.romwrite_data;    assign wadr[2] = bus_c.romwrite_addr;
    assign wdat[3] = bus_d.romwrite_data;    assign wadr[3] = bus_d.romwrite_addr;

    host_rom_loader #(.CONFIG_ON_STARTUP(1'b1), .ROM_LOCATION(LOC_STD), .ROM_BYTES(65536), .WR_PULSE(2))
        u_dut_a (.clk(clk), .reset(reset), .host_reset(hr[0]), .bus(bus_a), .rom_initialised(rinit[0]));
    host_rom_loader #(.CONFIG_ON_STARTUP(1'b1), .ROM_LOCATION(LOC_STD), .ROM_BYTES(6), .WR_PULSE(1))
        u_dut_b (.clk(clk), .reset(reset), .host_reset(hr[1]), .bus(bus_b), .rom_initialised(rinit[1]));
    host_rom_loader #(.CONFIG_ON_STARTUP(1'b1), .ROM_LOCATION(LOC_WRAP), .ROM_BYTES(4), .WR_PULSE(3))
        u_dut_c (.clk(clk), .reset(reset), .host_reset(hr[2]), .bus(bus_c), .rom_initialised(rinit[2]));
    host_rom_loader #(.CONFIG_ON_STARTUP(1'b0), .ROM_LOCATION(LOC_STD), .ROM_BYTES(65536), .WR_PULSE(2))
        u_dut_d (.clk(clk), .reset(reset), .host_reset(hr[3]), .bus(bus_d), .rom_initialised(rinit[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rb(input int k);
        return (k == 1) ? 6 : (k == 2) ? 4 : 65536;
    endfunction

    function automatic int wp(input int k);
        return (k == 1) ? 1 : (k == 2) ? 3 : 2;
    endfunction

    function automatic logic [18:0] loc(input int k);
        return (k == 2) ? LOC_WRAP : LOC_STD;
    endfunction

    function automatic logic [18:0] exp_addr(input int k, input int n);
        return 19'(32'(loc(k)) + 32'(n));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per-cycle observation of every instance's write port against the model
    task automatic mon();
        for (int k = 0; k < 4; k++) begin
            if (wr[k]) begin
                if (!in_pulse[k]) begin
                    in_pulse[k] = 1'b1;
                    plen[k]     = 1;
                    cur_d[k]    = wdat[k];
                    cur_a[k]    = wadr[k];
                    check($sformatf("setup_data[%0d]", k), 32'(wdat[k]), 32'(prev_d[k]));
                    check($sformatf("setup_addr[%0d]", k), 32'(wadr[k]), 32'(prev_a[k]));
                end else begin
                    plen[k]++;
                    check($sformatf("strobe_stable[%0d]", k), {wadr[k], wdat[k]}, {cur_a[k], cur_d[k]});
                end
                check($sformatf("init_low_in_load[%0d]", k), 32'(rinit[k]), 32'd0);
            end else if (in_pulse[k]) begin
                in_pulse[k] = 1'b0;
                check($sformatf("wr_len[%0d]", k), 32'(plen[k]), 32'(wp(k)));
                check($sformatf("hold_stable[%0d]", k), {wadr[k], wdat[k]}, {cur_a[k], cur_d[k]});
                check($sformatf("init_low_in_hold[%0d]", k), 32'(rinit[k]), 32'd0);
                check($sformatf("write_expected[%0d]", k),
                      32'(got_n[k] < exp_n[k] && got_n[k] < rb(k)), 32'd1);
                if (got_n[k] < exp_n[k] && got_n[k] < 64) begin
                    check($sformatf("write_data[%0d]", k), 32'(cur_d[k]), 32'(exp_byte[k][got_n[k]]));
                    check($sformatf("write_addr[%0d]", k), 32'(cur_a[k]), 32'(exp_addr(k, got_n[k])));
                end
                got_n[k]++;
                if (got_n[k] == rb(k)) exp_init[k] = 1'b1;
            end else if (exp_init[k]) begin
                exp_init[k] = 1'b0;
                check($sformatf("init_after_last_hold[%0d]", k), 32'(rinit[k]), 32'd1);
            end
            prev_d[k] = wdat[k];
            prev_a[k] = wadr[k];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    task automatic send_word(input int k, input logic [31:0] w, input int hold);
        bit seen;
        seen   = 1'b0;
        bd[k]  = w;
        req[k] = 1'b1;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick();
            if (ack[k]) seen = 1'b1;
        end
        check($sformatf("ack_seen[%0d]", k), 32'(seen), 32'd1);
        if (seen) begin
            check($sformatf("ack_setup_wr[%0d]", k), 32'(wr[k]), 32'd0);
            check($sformatf("ack_setup_data[%0d]", k), 32'(wdat[k]), 32'(w[31:24]));
            check($sformatf("ack_setup_addr[%0d]", k), 32'(wadr[k]), 32'(exp_addr(k, exp_n[k])));
            for (int i = 0; i < 4; i++) begin
                if (exp_n[k] < 64) begin
                    exp_byte[k][exp_n[k]] = w[8*(3-i) +: 8];
                    exp_n[k]++;
                end
            end
            for (int i = 0; i < hold; i++) begin
                tick();
                check($sformatf("ack_single_req_high[%0d]", k), 32'(ack[k]), 32'd0);
            end
        end
        req[k] = 1'b0;
        tick();
        check($sformatf("ack_single[%0d]", k), 32'(ack[k]), 32'd0);
    endtask

    task automatic expect_no_ack(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("no_ack[%0d]", k), 32'(ack[k]), 32'd0);
        end
    endtask

    task automatic hreset(input int k);
        hr[k]       = 1'b1;
        got_n[k]    = 0;
        exp_n[k]    = 0;
        in_pulse[k] = 1'b0;
        exp_init[k] = 1'b0;
        tick();
        hr[k] = 1'b0;
        check($sformatf("hr_wr[%0d]", k), 32'(wr[k]), 32'd0);
        check($sformatf("hr_addr[%0d]", k), 32'(wadr[k]), 32'(loc(k)));
        check($sformatf("hr_init[%0d]", k), 32'(rinit[k]), 32'd0);
        check($sformatf("hr_ack[%0d]", k), 32'(ack[k]), 32'd0);
    endtask

    initial begin
        bit found;
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < 4; k++) begin
            bd[k] = '0; req[k] = 1'b0; hr[k] = 1'b0;
            exp_n[k] = 0; got_n[k] = 0; in_pulse[k] = 1'b0; plen[k] = 0;
            cur_d[k] = '0; cur_a[k] = '0; prev_d[k] = '0; prev_a[k] = '0; exp_init[k] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_ack[%0d]", k), 32'(ack[k]), 32'd0);
            check($sformatf("rst_wr[%0d]", k), 32'(wr[k]), 32'd0);
            check($sformatf("rst_data[%0d]", k), 32'(wdat[k]), 32'd0);
            check($sformatf("rst_addr[%0d]", k), 32'(wadr[k]), 32'(loc(k)));
            check($sformatf("rst_init[%0d]", k), 32'(rinit[k]), (k == 3) ? 32'd1 : 32'd0);
        end
        reset = 1'b0;

        // instance A: fixed first word, req held past ack, then random words
        send_word(0, 32'h11223344, 3);
        send_word(0, $urandom, 20);
        send_word(0, $urandom, $urandom_range(0, 24));
        send_word(0, $urandom, 0);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick();
            if (wr[0] && wadr[0] == exp_addr(0, 14)) found = 1'b1;
        end
        check("hr_strobe_found", 32'(found), 32'd1);
        hreset(0);
        for (int n = 0; n < 8; n++) begin
            send_word(0, $urandom, $urandom_range(0, 24));
            repeat ($urandom_range(0, 4)) tick();
        end

        // instance B: six-byte image, tail of second word dropped
        send_word(1, 32'hAABBCCDD, 0);
        send_word(1, 32'hEEFF0102, 1);
        repeat (20) tick();
        check("b_init_done", 32'(rinit[1]), 32'd1);
        bd[1]  = $urandom;
        req[1] = 1'b1;
        expect_no_ack(1, 12);
        req[1] = 1'b0;

        // instance C: addresses wrap through the top of the 19-bit space
        send_word(2, $urandom, 2);
        repeat (25) tick();
        check("c_init_done", 32'(rinit[2]), 32'd1);
        bd[2]  = $urandom;
        req[2] = 1'b1;
        expect_no_ack(2, 8);
        req[2] = 1'b0;

        // instance D: idle after reset until host_reset
        check("d_init_idle", 32'(rinit[3]), 32'd1);
        bd[3]  = 32'h11223344;
        req[3] = 1'b1;
        expect_no_ack(3, 10);
        hreset(3);
        send_word(3, 32'h11223344, 0);
        send_word(3, $urandom, $urandom_range(0, 6));

        repeat (40) tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("write_count[%0d]", k), 32'(got_n[k]),
                  32'((exp_n[k] < rb(k)) ? exp_n[k] : rb(k)));
            check($sformatf("final_init[%0d]", k), 32'(rinit[k]), 32'(exp_n[k] >= rb(k)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
